// File: rtl/tilelink_nto1_arbiter.sv
// -----------------------------------------------------------------------------
// tilelink_nto1_arbiter
//   Shares one TileLink-UL slave port between NM masters.
//   A channel: round-robin arbitration. The grant is locked for every beat of a
//   multi-beat Put burst. The granted master's index is prepended to a_source.
//   D channel: each response is routed back using the upper source bits. The
//   other D fields go to every master. Only the addressed master sees d_valid.
//
// Ports
//   tilelink_clock_i / tilelink_reset_i : clock, synchronous active-high reset
//   m_a_*        : per-master A channel, packed (master k at [k*W +: W])
//   m_a_ready    : per-master A ready
//   m_d_*        : D channel fields sent to all masters, with the master index
//                  removed from the source
//   m_d_valid    : per-master D valid, one-hot
//   m_d_ready    : per-master D ready
//   s_a_*        : A channel to the slave, source = {idx, master source}
//   s_d_*        : D channel from the slave, source = {idx, master source}
// -----------------------------------------------------------------------------
module tilelink_nto1_arbiter #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int RS = 4,
  localparam int MW  = $clog2(NM),
  localparam int BB  = DW / 8,
  localparam int LBB = $clog2(BB)
) (
  input  logic                tilelink_clock_i,
  input  logic                tilelink_reset_i,
  // master-side A
  input  logic [NM*3-1:0]     m_a_opcode,
  input  logic [NM*3-1:0]     m_a_param,
  input  logic [NM*4-1:0]     m_a_size,
  input  logic [NM*RS-1:0]    m_a_source,
  input  logic [NM*AW-1:0]    m_a_address,
  input  logic [NM*BB-1:0]    m_a_mask,
  input  logic [NM*DW-1:0]    m_a_data,
  input  logic [NM-1:0]       m_a_corrupt,
  input  logic [NM-1:0]       m_a_valid,
  output logic [NM-1:0]       m_a_ready,
  // master-side D
  output logic [2:0]          m_d_opcode,
  output logic [1:0]          m_d_param,
  output logic [3:0]          m_d_size,
  output logic [RS-1:0]       m_d_source,
  output logic                m_d_denied,
  output logic                m_d_corrupt,
  output logic [DW-1:0]       m_d_data,
  output logic [NM-1:0]       m_d_valid,
  input  logic [NM-1:0]       m_d_ready,
  // slave-side A
  output logic [2:0]          s_a_opcode,
  output logic [2:0]          s_a_param,
  output logic [3:0]          s_a_size,
  output logic [RS+MW-1:0]    s_a_source,
  output logic [AW-1:0]       s_a_address,
  output logic [BB-1:0]       s_a_mask,
  output logic [DW-1:0]       s_a_data,
  output logic                s_a_corrupt,
  output logic                s_a_valid,
  input  logic                s_a_ready,
  // slave-side D
  input  logic [2:0]          s_d_opcode,
  input  logic [1:0]          s_d_param,
  input  logic [3:0]          s_d_size,
  input  logic [RS+MW-1:0]    s_d_source,
  input  logic                s_d_denied,
  input  logic                s_d_corrupt,
  input  logic [DW-1:0]       s_d_data,
  input  logic                s_d_valid,
  output logic                s_d_ready
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  logic          fsm_reg, fsm_next;
  logic [MW-1:0] grant_reg, grant_next;
  logic [MW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [15:0]   beats_left_reg, beats_left_next;
  // In IDLE, hold_sel_reg keeps an offered but unaccepted request stable.
  // Without it, a new valid from a higher-priority master could change s_a_*
  // before the current request fires.
  logic          hold_valid_reg, hold_valid_next;
  logic [MW-1:0] hold_sel_reg, hold_sel_next;

  logic [MW-1:0] rr_sel, sel;
  logic          a_valid, fire;
  logic [15:0]   sel_beats;
  logic [MW-1:0] d_idx;
  logic          d_ready_sel;
  int            cand;

  function automatic logic [MW-1:0] next_idx(input logic [MW-1:0] i);
    return (int'(i) == NM - 1) ? '0 : i + MW'(1);
  endfunction

  // Round-robin search. Candidates are scanned from farthest to nearest, so
  // the last match found is the nearest valid master at or after rr_ptr.
  always_comb begin
    rr_sel = rr_ptr_reg;
    cand   = 0;
    for (int off = NM - 1; off >= 0; off--) begin
      cand = int'(rr_ptr_reg) + off;
      if (cand >= NM) cand = cand - NM;
      if (m_a_valid[MW'(cand)]) rr_sel = MW'(cand);
    end
  end

  always_comb begin
    if (fsm_reg == ST_BURST) begin
      sel     = grant_reg;
      a_valid = m_a_valid[grant_reg];
    end else if (hold_valid_reg) begin
      sel     = hold_sel_reg;
      a_valid = m_a_valid[hold_sel_reg];
    end else begin
      sel     = rr_sel;
      a_valid = |m_a_valid;
    end
  end

  assign s_a_valid = a_valid && !tilelink_reset_i;
  assign fire      = s_a_valid && s_a_ready;

  // A-channel field multiplexer
  always_comb begin
    s_a_opcode  = '0;
    s_a_param   = '0;
    s_a_size    = '0;
    s_a_source  = '0;
    s_a_address = '0;
    s_a_mask    = '0;
    s_a_data    = '0;
    s_a_corrupt = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (sel == MW'(k)) begin
        s_a_opcode  = m_a_opcode[k*3 +: 3];
        s_a_param   = m_a_param[k*3 +: 3];
        s_a_size    = m_a_size[k*4 +: 4];
        s_a_source  = {MW'(k), m_a_source[k*RS +: RS]};
        s_a_address = m_a_address[k*AW +: AW];
        s_a_mask    = m_a_mask[k*BB +: BB];
        s_a_data    = m_a_data[k*DW +: DW];
        s_a_corrupt = m_a_corrupt[k];
      end
    end
  end

  // Only PutFull/PutPartial carry data across several beats. Get requests
  // always take one beat on A, whatever their size.
  always_comb begin
    sel_beats = 16'd1;
    if ((s_a_opcode == 3'd0 || s_a_opcode == 3'd1) && s_a_size > 4'(LBB))
      sel_beats = 16'd1 << (s_a_size - 4'(LBB));
  end

  always_comb begin
    fsm_next        = fsm_reg;
    grant_next      = grant_reg;
    rr_ptr_next     = rr_ptr_reg;
    beats_left_next = beats_left_reg;
    hold_valid_next = hold_valid_reg;
    hold_sel_next   = hold_sel_reg;
    if (fire) begin
      hold_valid_next = 1'b0;
      if (fsm_reg == ST_BURST) begin
        beats_left_next = beats_left_reg - 16'd1;
        if (beats_left_reg == 16'd1) begin
          fsm_next    = ST_IDLE;
          rr_ptr_next = next_idx(grant_reg);
        end
      end else if (sel_beats > 16'd1) begin
        fsm_next        = ST_BURST;
        grant_next      = sel;
        beats_left_next = sel_beats - 16'd1;
      end else begin
        rr_ptr_next = next_idx(sel);
      end
    end else if (fsm_reg == ST_IDLE && s_a_valid) begin
      hold_valid_next = 1'b1;
      hold_sel_next   = sel;
    end
  end

  always_ff @(posedge tilelink_clock_i) begin
    if (tilelink_reset_i) begin
      fsm_reg        <= ST_IDLE;
      grant_reg      <= '0;
      rr_ptr_reg     <= '0;
      beats_left_reg <= '0;
      hold_valid_reg <= 1'b0;
      hold_sel_reg   <= '0;
    end else begin
      fsm_reg        <= fsm_next;
      grant_reg      <= grant_next;
      rr_ptr_reg     <= rr_ptr_next;
      beats_left_reg <= beats_left_next;
      hold_valid_reg <= hold_valid_next;
      hold_sel_reg   <= hold_sel_next;
    end
  end

  // D channel: route each beat by the master index in the upper source bits
  assign d_idx       = s_d_source[RS+MW-1:RS];
  assign m_d_opcode  = s_d_opcode;
  assign m_d_param   = s_d_param;
  assign m_d_size    = s_d_size;
  assign m_d_source  = s_d_source[RS-1:0];
  assign m_d_denied  = s_d_denied;
  assign m_d_corrupt = s_d_corrupt;
  assign m_d_data    = s_d_data;

  // An index with no matching master keeps the default of 1, so that beat is
  // accepted and dropped. This stops a bad source from stalling the D channel.
  always_comb begin
    d_ready_sel = 1'b1;
    for (int k = 0; k < NM; k++)
      if (d_idx == MW'(k)) d_ready_sel = m_d_ready[k];
  end
  assign s_d_ready = d_ready_sel && !tilelink_reset_i;

  for (genvar gi = 0; gi < NM; gi++) begin : g_master
    assign m_a_ready[gi] = fire && (sel == MW'(gi));
    assign m_d_valid[gi] = s_d_valid && !tilelink_reset_i && (d_idx == MW'(gi));
  end

endmodule

// File: tb/tb_tilelink_nto1_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tilelink_nto1_arbiter
//   Directed scenarios and a random run for the 2-master TileLink arbiter.
//   The expected grants come from a reference model in this file. The model
//   tracks the round-robin pointer, the locked burst and the held offer.
// -----------------------------------------------------------------------------
module tb_tilelink_nto1_arbiter;
  localparam int NM = 2, AW = 32, DW = 32, RS = 4, BB = 4, MW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  // per-master A stimulus
  logic [2:0]    a_op  [NM];
  logic [2:0]    a_par [NM];
  logic [3:0]    a_sz  [NM];
  logic [RS-1:0] a_src [NM];
  logic [AW-1:0] a_adr [NM];
  logic [BB-1:0] a_msk [NM];
  logic [DW-1:0] a_dat [NM];
  logic          a_cor [NM];
  logic [NM-1:0] a_vld;
  logic          s_rdy;

  logic [NM*3-1:0]  m_a_opcode, m_a_param;
  logic [NM*4-1:0]  m_a_size;
  logic [NM*RS-1:0] m_a_source;
  logic [NM*AW-1:0] m_a_address;
  logic [NM*BB-1:0] m_a_mask;
  logic [NM*DW-1:0] m_a_data;
  logic [NM-1:0]    m_a_corrupt, m_a_ready;
  logic [2:0]       m_d_opcode;
  logic [1:0]       m_d_param;
  logic [3:0]       m_d_size;
  logic [RS-1:0]    m_d_source;
  logic             m_d_denied, m_d_corrupt;
  logic [DW-1:0]    m_d_data;
  logic [NM-1:0]    m_d_valid, m_d_ready;
  logic [2:0]       s_a_opcode, s_a_param;
  logic [3:0]       s_a_size;
  logic [RS+MW-1:0] s_a_source;
  logic [AW-1:0]    s_a_address;
  logic [BB-1:0]    s_a_mask;
  logic [DW-1:0]    s_a_data;
  logic             s_a_corrupt, s_a_valid;
  logic [2:0]       s_d_opcode;
  logic [1:0]       s_d_param;
  logic [3:0]       s_d_size;
  logic [RS+MW-1:0] s_d_source;
  logic             s_d_denied, s_d_corrupt, s_d_valid, s_d_ready;
  logic [DW-1:0]    s_d_data;

  always_comb begin
    m_a_opcode = '0; m_a_param = '0; m_a_size = '0; m_a_source = '0;
    m_a_address = '0; m_a_mask = '0; m_a_data = '0; m_a_corrupt = '0;
    for (int k = 0; k < NM; k++) begin
      m_a_opcode[k*3 +: 3]    = a_op[k];
      m_a_param[k*3 +: 3]     = a_par[k];
      m_a_size[k*4 +: 4]      = a_sz[k];
      m_a_source[k*RS +: RS]  = a_src[k];
      m_a_address[k*AW +: AW] = a_adr[k];
      m_a_mask[k*BB +: BB]    = a_msk[k];
      m_a_data[k*DW +: DW]    = a_dat[k];
      m_a_corrupt[k]          = a_cor[k];
    end
  end

  tilelink_nto1_arbiter #(.NM(NM), .AW(AW), .DW(DW), .RS(RS)) dut (
    .tilelink_clock_i(clk), .tilelink_reset_i(rst),
    .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size),
    .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask),
    .m_a_data(m_a_data), .m_a_corrupt(m_a_corrupt), .m_a_valid(a_vld),
    .m_a_ready(m_a_ready),
    .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size),
    .m_d_source(m_d_source), .m_d_denied(m_d_denied), .m_d_corrupt(m_d_corrupt),
    .m_d_data(m_d_data), .m_d_valid(m_d_valid), .m_d_ready(m_d_ready),
    .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
    .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
    .s_a_data(s_a_data), .s_a_corrupt(s_a_corrupt), .s_a_valid(s_a_valid),
    .s_a_ready(s_rdy),
    .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
    .s_d_source(s_d_source), .s_d_denied(s_d_denied), .s_d_corrupt(s_d_corrupt),
    .s_d_data(s_d_data), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int rr_m, lock_m, left_m, hold_m, fired_m;

  function automatic int beats_of(input logic [2:0] op, input logic [3:0] sz);
    if (op <= 3'd1 && sz > 4'd2) return 1 << (int'(sz) - 2);
    return 1;
  endfunction

  // Master whose request the slave should be offered, or -1 if none
  function automatic int exp_sel();
    if (lock_m >= 0) return lock_m;
    if (hold_m >= 0) return hold_m;
    for (int o = 0; o < NM; o++)
      if (a_vld[(rr_m + o) % NM]) return (rr_m + o) % NM;
    return -1;
  endfunction

  function automatic bit exp_valid();
    int s;
    s = exp_sel();
    return (s >= 0) && a_vld[s];
  endfunction

  task automatic model_reset();
    rr_m = 0; lock_m = -1; left_m = 0; hold_m = -1; fired_m = -1;
  endtask

  // Advance the model by one clock, using the inputs currently driven
  task automatic model_step();
    int s, nb;
    s = exp_sel();
    fired_m = -1;
    if (exp_valid() && s_rdy) begin
      fired_m = s;
      hold_m  = -1;
      if (lock_m >= 0) begin
        left_m--;
        if (left_m == 0) begin
          rr_m = (lock_m + 1) % NM;
          lock_m = -1;
        end
      end else begin
        nb = beats_of(a_op[s], a_sz[s]);
        if (nb > 1) begin lock_m = s; left_m = nb - 1; end
        else rr_m = (s + 1) % NM;
      end
    end else if (lock_m < 0 && exp_valid()) begin
      hold_m = s;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_vld = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_req(input int k, input logic [2:0] op, input logic [3:0] sz,
                         input logic [RS-1:0] src, input logic [DW-1:0] dat);
    a_op[k] = op; a_par[k] = 3'd0; a_sz[k] = sz; a_src[k] = src;
    a_adr[k] = 32'h1000 * (k + 1); a_msk[k] = 4'hF; a_dat[k] = dat; a_cor[k] = 1'b0;
    a_vld[k] = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; s_rdy = 1'b1;
    set_req(0, 3'd4, 4'd2, 4'h1, 32'h11);
    set_req(1, 3'd4, 4'd2, 4'h2, 32'h22);
    s_d_valid = 1'b1; s_d_source = 5'b0_0001; m_d_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 4;
      if (m_a_ready !== 2'b00) begin errors++; $display("FAIL rst_m_a_ready: got %b want 00", m_a_ready); end
      if (s_a_valid !== 1'b0) begin errors++; $display("FAIL rst_s_a_valid: got %b want 0", s_a_valid); end
      if (m_d_valid !== 2'b00) begin errors++; $display("FAIL rst_m_d_valid: got %b want 00", m_d_valid); end
      if (s_d_ready !== 1'b0) begin errors++; $display("FAIL rst_s_d_ready: got %b want 0", s_d_ready); end
      @(posedge clk);
      #1;
    end
    rst = 1'b0; model_reset(); s_d_valid = 1'b0;
    @(negedge clk);
    checks += 4;
    if (s_a_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid: got %b want 1", s_a_valid); end
    if (s_a_source !== 5'h01) begin errors++; $display("FAIL post_rst_source: got %h want 01", s_a_source); end
    if (m_a_ready !== 2'b01) begin errors++; $display("FAIL post_rst_ready: got %b want 01", m_a_ready); end
    if (s_a_data !== 32'h11) begin errors++; $display("FAIL post_rst_data: got %h want 11", s_a_data); end
    tick();
  endtask

  task automatic test_rr_get();
    int exp_g[4] = '{0, 1, 0, 1};
    logic eb;
    do_reset();
    set_req(0, 3'd4, 4'd2, 4'h5, 32'h50);
    set_req(1, 3'd4, 4'd2, 4'h6, 32'h60);
    s_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      eb = exp_g[i][0];
      checks += 2;
      if (s_a_source[RS] !== eb) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, s_a_source[RS], eb); end
      if (s_a_source[RS-1:0] !== a_src[exp_g[i]]) begin errors++; $display("FAIL rr_src[%0d]: got %h want %h", i, s_a_source[RS-1:0], a_src[exp_g[i]]); end
      $display("rr beat %0d master %0d", i, s_a_source[RS]);
      tick();
    end
    a_vld = '0;
  endtask

  task automatic test_burst();
    int em;
    logic [DW-1:0] ed;
    do_reset();
    set_req(0, 3'd0, 4'd4, 4'h3, 32'hA0);
    set_req(1, 3'd4, 4'd2, 4'h5, 32'hB0);
    s_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      em = (i < 4) ? 0 : 1;
      ed = (i < 4) ? 32'hA0 + DW'(i) : 32'hB0;
      checks += 3;
      if (int'(s_a_source[RS]) != em) begin errors++; $display("FAIL burst_grant[%0d]: got %0d want %0d", i, s_a_source[RS], em); end
      if (s_a_data !== ed) begin errors++; $display("FAIL burst_data[%0d]: got %h want %h", i, s_a_data, ed); end
      if (int'(s_a_source[RS]) != exp_sel()) begin errors++; $display("FAIL burst_model[%0d]: got %0d want %0d", i, s_a_source[RS], exp_sel()); end
      $display("burst beat %0d master %0d data %h", i, s_a_source[RS], s_a_data);
      tick();
      if (i < 3) a_dat[0] = 32'hA0 + DW'(i + 1);
      else if (i == 3) set_req(0, 3'd4, 4'd2, 4'h3, 32'hC0);
    end
    a_vld = '0;
  endtask

  task automatic test_stall_burst();
    int pat[12] = '{0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1};
    int done, em;
    bit m1_done;
    logic [NM-1:0] er;
    do_reset();
    set_req(0, 3'd0, 4'd4, 4'h3, 32'hD0);
    set_req(1, 3'd4, 4'd2, 4'h6, 32'hE0);
    done = 0; m1_done = 0;
    for (int i = 0; i < 12; i++) begin
      s_rdy = pat[i][0];
      @(negedge clk);
      if (m1_done) begin
        checks++;
        if (s_a_valid !== 1'b0) begin errors++; $display("FAIL stall_idle[%0d]: got %b want 0", i, s_a_valid); end
      end else begin
        em = (done < 4) ? 0 : 1;
        er = s_rdy ? 2'(1 << em) : 2'b00;
        checks += 3;
        if (int'(s_a_source[RS]) != em) begin errors++; $display("FAIL stall_grant[%0d]: got %0d want %0d", i, s_a_source[RS], em); end
        if (s_a_data !== ((em == 0) ? 32'hD0 + DW'(done) : 32'hE0)) begin errors++; $display("FAIL stall_data[%0d]: got %h", i, s_a_data); end
        if (m_a_ready !== er) begin errors++; $display("FAIL stall_ready[%0d]: got %b want %b", i, m_a_ready, er); end
        if (s_rdy) $display("stall fire master %0d data %h", em, s_a_data);
      end
      tick();
      if (pat[i] != 0 && !m1_done) begin
        if (em == 0) begin
          done++;
          if (done < 4) a_dat[0] = 32'hD0 + DW'(done); else a_vld[0] = 1'b0;
        end else begin
          m1_done = 1; a_vld[1] = 1'b0;
        end
      end
    end
    checks++;
    if (done != 4 || !m1_done) begin errors++; $display("FAIL stall_complete: got %0d beats m1 %0d want 4 beats m1 1", done, m1_done); end
  endtask

  task automatic test_d_route();
    a_vld = '0; s_rdy = 1'b0;
    s_d_source = 5'b1_0011; s_d_valid = 1'b1; m_d_ready = 2'b01;
    s_d_data = 32'hCAFE_0001; s_d_opcode = 3'd1; s_d_size = 4'd2;
    @(negedge clk);
    checks += 3;
    if (m_d_valid !== 2'b10) begin errors++; $display("FAIL d_valid: got %b want 10", m_d_valid); end
    if (s_d_ready !== 1'b0) begin errors++; $display("FAIL d_ready_blocked: got %b want 0", s_d_ready); end
    if (m_d_data !== 32'hCAFE_0001) begin errors++; $display("FAIL d_data: got %h want cafe0001", m_d_data); end
    tick();
    m_d_ready = 2'b10;
    @(negedge clk);
    checks += 3;
    if (s_d_ready !== 1'b1) begin errors++; $display("FAIL d_ready_fire: got %b want 1", s_d_ready); end
    if (m_d_source !== 4'h3) begin errors++; $display("FAIL d_source: got %h want 3", m_d_source); end
    if (m_d_opcode !== 3'd1) begin errors++; $display("FAIL d_opcode: got %0d want 1", m_d_opcode); end
    $display("d beat to master 1 source %h", m_d_source);
    tick();
    s_d_source = 5'b0_1010; m_d_ready = 2'b01;
    @(negedge clk);
    checks += 2;
    if (m_d_valid !== 2'b01) begin errors++; $display("FAIL d_valid_m0: got %b want 01", m_d_valid); end
    if (s_d_ready !== 1'b1) begin errors++; $display("FAIL d_ready_m0: got %b want 1", s_d_ready); end
    tick();
    s_d_valid = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    set_req(0, 3'd4, 4'd2, 4'h7, 32'h70);
    s_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (s_a_source[RS] !== 1'b0) begin errors++; $display("FAIL hold_first: got %b want 0", s_a_source[RS]); end
    tick();                                   // m0 fired, pointer now favours m1
    a_dat[0] = 32'h71; s_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 3;
      if (s_a_source[RS] !== 1'b0) begin errors++; $display("FAIL hold_sel[%0d]: got %b want 0", i, s_a_source[RS]); end
      if (s_a_data !== 32'h71) begin errors++; $display("FAIL hold_data[%0d]: got %h want 71", i, s_a_data); end
      if (m_a_ready !== 2'b00) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 00", i, m_a_ready); end
      tick();
      if (i == 0) set_req(1, 3'd4, 4'd2, 4'h8, 32'h80);
    end
    s_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (m_a_ready !== 2'b01) begin errors++; $display("FAIL hold_fire: got %b want 01", m_a_ready); end
    tick();
    a_vld[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (s_a_source !== 5'h18) begin errors++; $display("FAIL hold_next: got %h want 18", s_a_source); end
    tick();
    a_vld = '0;
  endtask

  task automatic test_random();
    int brem[NM];
    int es, k, idx;
    bit ev;
    logic [NM-1:0] er, edv;
    do_reset();
    for (int m = 0; m < NM; m++) brem[m] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < NM; m++) begin
        if (!a_vld[m] && $urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 2))
            0: set_req(m, 3'd0, 4'($urandom_range(0, 4)), 4'($urandom), $urandom);
            1: set_req(m, 3'd1, 4'($urandom_range(0, 4)), 4'($urandom), $urandom);
            default: set_req(m, 3'd4, 4'($urandom_range(0, 4)), 4'($urandom), $urandom);
          endcase
          brem[m] = beats_of(a_op[m], a_sz[m]);
        end
      end
      s_rdy = ($urandom_range(0, 3) != 0);
      s_d_valid = 1'($urandom); s_d_source = 5'($urandom);
      m_d_ready = 2'($urandom); s_d_data = $urandom;
      @(negedge clk);
      es = exp_sel(); ev = exp_valid();
      idx = int'(s_d_source[RS]);
      checks += 4;
      if (s_a_valid !== ev) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, s_a_valid, ev); end
      er = (ev && s_rdy) ? 2'(1 << es) : 2'b00;
      if (m_a_ready !== er) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, m_a_ready, er); end
      edv = s_d_valid ? 2'(1 << idx) : 2'b00;
      if (m_d_valid !== edv) begin errors++; $display("FAIL rnd_d_valid[%0d]: got %b want %b", c, m_d_valid, edv); end
      if (s_d_ready !== m_d_ready[idx] || m_d_source !== s_d_source[RS-1:0]) begin
        errors++; $display("FAIL rnd_d_route[%0d]: got rdy %b src %h want rdy %b src %h", c, s_d_ready, m_d_source, m_d_ready[idx], s_d_source[RS-1:0]);
      end
      if (ev) begin
        checks += 2;
        if (int'(s_a_source[RS]) != es || s_a_source[RS-1:0] !== a_src[es]) begin
          errors++; $display("FAIL rnd_source[%0d]: got %h want master %0d src %h", c, s_a_source, es, a_src[es]);
        end
        if (s_a_data !== a_dat[es] || s_a_size !== a_sz[es] || s_a_opcode !== a_op[es]) begin
          errors++; $display("FAIL rnd_fields[%0d]: got op %0d sz %0d data %h want op %0d sz %0d data %h", c, s_a_opcode, s_a_size, s_a_data, a_op[es], a_sz[es], a_dat[es]);
        end
        if (s_rdy) $display("rnd A fire cycle %0d master %0d op %0d size %0d data %h", c, es, a_op[es], a_sz[es], a_dat[es]);
      end
      tick();
      if (fired_m >= 0) begin
        k = fired_m;
        brem[k]--;
        if (brem[k] <= 0) a_vld[k] = 1'b0;
        else begin a_dat[k] = $urandom; a_msk[k] = 4'($urandom); end
      end
    end
    a_vld = '0; s_d_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_rdy = 1'b0; a_vld = '0;
    for (int k = 0; k < NM; k++) begin
      a_op[k] = '0; a_par[k] = '0; a_sz[k] = '0; a_src[k] = '0;
      a_adr[k] = '0; a_msk[k] = '0; a_dat[k] = '0; a_cor[k] = 1'b0;
    end
    s_d_opcode = '0; s_d_param = '0; s_d_size = '0; s_d_source = '0;
    s_d_denied = 1'b0; s_d_corrupt = 1'b0; s_d_data = '0; s_d_valid = 1'b0;
    m_d_ready = '0;
    model_reset();
    test_reset();
    test_rr_get();
    test_burst();
    test_stall_burst();
    test_d_route();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
